apb_master: RTL and testbench

Single-outstanding APB initiator that turns a simple valid/ready command interface into APB SETUP/ACCESS transfers. It drives the APB slave port of the UART top level, so firmware-less test harnesses and on-chip sequencers can program the baud divisor and drain the RX FIFO. Each accepted command produces exactly one APB transfer and one response pulse.

---
 rtl/apb_master.sv | 153 +++++++++++++++
 tb/tb_apb_master.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready command in, one SETUP/ACCESS transfer and one response pulse out.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master #(
    parameter int APB_DW  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_DW-1:0] cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_DW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [APB_DW-1:0] PRDATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [APB_DW-1:0] paddr_q, paddr_d;
    logic [APB_DW-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    // Counter holds the number of PREADY-low ACCESS cycles already seen.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    state_d     = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    // Without the timeout there is no abort path, so the error flag never rises.
    assign rsp_err   = 1'b0;
    logic unused_err;
    assign unused_err = rsp_err_d;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: table of single transfers plus hand-written
// back-to-back, stuck-slave and mid-transfer reset sequences.
module tb_apb_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       PSEL, PENABLE, PWRITE, PREADY;
    logic [7:0] PADDR, PWDATA, PRDATA;

    int total = 0;
    int bad   = 0;

    apb_master #(.APB_DW(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic [7:0] prdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; leaves the DUT in reset-released IDLE.
    task automatic pulse_reset(input string nm);
        rst = 1'b0;
        #1;
        chk({nm, " rst apb"}, {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        chk({nm, " rst rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
        tick();
        chk({nm, " rst no rsp"}, {rsp_valid, PSEL}, 0);
        @(negedge clk);
        rst = 1'b1;
        PREADY = 1'b0;
        tick();
        chk({nm, " post rst"}, {cmd_ready, rsp_valid, PSEL}, 3'b100);
    endtask

    // Cycle-exact single transfer; caller is just after a rising edge with DUT in IDLE.
    task automatic do_txn(input string nm, input vec_t v);
        chk({nm, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        PREADY = 1'b0; PRDATA = 8'hEE;
        tick();
        cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00; cmd_write = ~v.wr;
        chk({nm, " setup"}, {cmd_ready, PSEL, PENABLE, rsp_valid}, 4'b0100);
        chk({nm, " fields"}, {PWRITE, PADDR, PWDATA}, {v.wr, v.addr, v.wdata});
        for (int k = 0; k <= v.waits; k++) begin
            tick();
            chk({nm, " access"}, {cmd_ready, PSEL, PENABLE, rsp_valid}, 4'b0110);
            chk({nm, " hold"}, {PWRITE, PADDR, PWDATA}, {v.wr, v.addr, v.wdata});
            PREADY = (k == v.waits);
            PRDATA = (k == v.waits) ? v.prdata : 8'hEE;
        end
        tick();
        PREADY = 1'b0; PRDATA = 8'hEE;
        chk({nm, " rsp"}, {rsp_valid, rsp_err, PSEL, PENABLE, cmd_ready}, 5'b10001);
        chk({nm, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({nm, " retain"}, {PWRITE, PADDR, PWDATA}, {v.wr, v.addr, v.wdata});
        tick();
        chk({nm, " pulse"}, {rsp_valid, rsp_err}, 0);
        chk({nm, " rdata hold"}, rsp_rdata, v.exp_rdata);
    endtask

    logic [5:0] psel_seen, rv_seen;

    initial begin
        vecs[0] = '{1'b1, 8'h04, 8'hA5, 0, 8'h77, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 3, 8'h3C, 8'h3C};
        vecs[2] = '{1'b1, 8'h10, 8'h5A, 1, 8'h66, 8'h00};
        vecs[3] = '{1'b0, 8'hFF, 8'h12, 0, 8'hC3, 8'hC3};
        vecs[4] = '{1'b0, 8'h22, 8'h00, 7, 8'h5E, 8'h5E};
        vecs[5] = '{1'b1, 8'h80, 8'hFF, 2, 8'h11, 8'h00};

        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
        cmd_wdata = 8'h00; PREADY = 1'b0; PRDATA = 8'h00;
        #1;
        chk("reset apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
        chk("reset rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        tick();
        chk("reset ready", cmd_ready, 1);

        for (int i = 0; i < 6; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back: cmd_valid held across a write then a read.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h08; cmd_wdata = 8'h11;
        PREADY = 1'b1; PRDATA = 8'h99;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) begin cmd_write = 1'b0; cmd_addr = 8'h0C; cmd_wdata = 8'h00; end
            psel_seen[i-1] = PSEL;
            rv_seen[i-1]   = rsp_valid;
            if (i == 3) chk("b2b wr rdata", rsp_rdata, 8'h00);
            if (i == 4) begin
                chk("b2b rd fields", {PWRITE, PADDR}, {1'b0, 8'h0C});
                cmd_valid = 1'b0;
            end
            if (i == 6) chk("b2b rd rdata", rsp_rdata, 8'h99);
        end
        chk("b2b psel", psel_seen, 6'b011011);
        chk("b2b rsp_valid", rv_seen, 6'b100100);
        PREADY = 1'b0;
        tick();
        chk("b2b idle", {cmd_ready, PSEL, rsp_valid}, 3'b100);

        // Slave stuck with PREADY low.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30;
        tick();
        cmd_valid = 1'b0;
        chk("stuck setup", {PSEL, PENABLE}, 2'b10);
`ifdef APB_TIMEOUT_EN
        for (int i = 2; i <= 10; i++) begin
            tick();
            if (i < 10) chk("stuck wait", {PSEL, PENABLE, rsp_valid}, 3'b110);
            else begin
                chk("abort rsp", {rsp_valid, rsp_err, PSEL, PENABLE}, 4'b1100);
                chk("abort rdata", rsp_rdata, 8'h00);
            end
        end
        tick();
        chk("abort pulse", {rsp_valid, rsp_err, cmd_ready}, 3'b001);
`else
        for (int i = 2; i <= 101; i++) begin
            tick();
            chk("stuck wait", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b1100);
        end
        pulse_reset("stuck");
`endif

        // Reset during the 2nd ACCESS cycle of a read.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("mid access", {PSEL, PENABLE}, 2'b11);
        PREADY = 1'b1; PRDATA = 8'h55;
        pulse_reset("mid");
        do_txn("after rst", '{1'b1, 8'h10, 8'hC7, 0, 8'h55, 8'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
